// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state codes (used by rx, baud gen and tx).
// Latency: n/a (definitions only).
// Backpressure: n/a.
package uart_pkg;

  // Oversampling ratio of the baud tick relative to the bit rate.
  localparam int OSR = 16;
  localparam int CNT_W = $clog2(OSR);

  // Tick indices within one bit period: mid-bit and last tick of the bit.
  localparam logic [CNT_W-1:0] MID_TICK  = CNT_W'(7);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(15);

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous level input, reset to idle-high.
// Latency: STAGES clk from pin to q.
// Backpressure: none; free-running.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  // Shift the raw input through the flop chain; reset to 1 so an idle line never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '1;
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], d};
    end
  end

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/uart_rx16.sv
// 16x-oversampled async serial receiver (LSB first, 1 stop) with valid/ready byte output.
// Latency: rx_valid rises 1 clk after the mid-stop-bit tick that completes the frame.
// Backpressure: one-byte holding register; a byte arriving while it is full and not being taken is dropped (overrun).
module uart_rx16
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick16,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic                 rxs;
  rx_state_t            state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [BIT_W-1:0]     bit_idx, bit_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 deliver;
  logic                 ferr_set;

  uart_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxs)
  );

  // Frame state, oversample counter, bit index and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shreg   <= shreg_nxt;
    end
  end

  // Next-state logic: counters only move on tick16, sampling happens at mid-bit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    deliver   = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_nxt = '0;
        if (!rxs) begin
          state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (tick16) begin
          if (cnt == MID_TICK) begin
            cnt_nxt   = '0;
            bit_nxt   = '0;
            // A line that is back high at mid-start was a glitch.
            state_nxt = rxs ? RX_IDLE : RX_DATA;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (tick16) begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST_TICK) begin
            shreg_nxt = {rxs, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
              state_nxt = RX_STOP;
            end else begin
              bit_nxt = bit_idx + 1'b1;
            end
          end
        end
      end
      RX_STOP: begin
        if (tick16) begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST_TICK) begin
            // Leaving at mid-stop gives half a bit of slack before the next start edge.
            if (rxs) begin
              deliver   = 1'b1;
              state_nxt = RX_IDLE;
            end else begin
              ferr_set  = 1'b1;
              state_nxt = RX_BREAK;
            end
          end
        end
      end
      RX_BREAK: begin
        // Stay here while the line is held low so a break reports only once.
        if (rxs) begin
          state_nxt = RX_IDLE;
        end
      end
      default: begin
        state_nxt = RX_IDLE;
      end
    endcase
  end

  // Output holding register and the registered one-clk error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      overrun   <= 1'b0;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          // Empty, or the held byte leaves this same clk: load the new one.
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx16.sv
// Bench for uart_rx16: directed frame scenarios plus randomized byte stream.
// Reference: bytes sent are queued by the bench and compared to bytes handed over.
// Error pulses and valid rises are counted by a passive monitor.
module tb_uart_rx16;

  localparam int DB      = 8;
  localparam int BIT_CLK = 64;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          tick16   = 1'b0;
  logic          rxd      = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          busy;
  logic          frame_err;
  logic          overrun;

  int tests = 0;
  int fails = 0;
  int tph   = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int vrise_cnt = 0;
  logic prev_valid = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_rx16 #(
    .DATA_BITS   (DB),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick16    (tick16),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #10 clk = ~clk;

  // 16x tick: one clk high out of every four, changed on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      tick16 = (tph == 3);
      tph = (tph + 1) % 4;
    end
  end

  // Passive monitor: record accepted bytes and count pulses/rises.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (rx_valid && !prev_valid) vrise_cnt++;
      prev_valid = rx_valid;
    end
  end

  initial begin
    #50000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pop_got();
    if (got_q.size() == 0) return 8'hxx;
    return got_q.pop_front();
  endfunction

  // All line-driving tasks start and end 1 time unit after a rising edge.
  task automatic hold(input logic v, input int n);
    rxd = v;
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < DB; i++) hold(b[i], BIT_CLK);
    hold(stop_v, BIT_CLK);
  endtask

  task automatic align();
    while (tph != 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  int         k, n, ov_len, fe0, ov0, vr0, gap;
  logic       found;
  logic [7:0] b;

  initial begin
    // Reset state
    repeat (5) @(posedge clk);
    #1;
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    hold(1'b1, 20);

    // 1: clean frame, consumer always ready
    rx_ready = 1'b1;
    got_q.delete();
    send_frame(8'hA5, 1'b1);
    hold(1'b1, 10);
    chk("t1_count", got_q.size(), 1);
    chk("t1_data", pop_got(), 8'hA5);
    chk("t1_ferr", fe_cnt, 0);
    chk("t1_busy", busy, 0);
    chk("t1_vrise", vrise_cnt, 1);

    // 2: short low glitch is rejected at mid-start
    hold(1'b0, 12);
    chk("t2_busy_hi", busy, 1);
    hold(1'b0, 8);
    hold(1'b1, 200);
    chk("t2_busy_lo", busy, 0);
    chk("t2_vrise", vrise_cnt, 1);
    chk("t2_ferr", fe_cnt, 0);

    // 3: bad stop bit then held-low line -> single frame error
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    hold(1'b0, 3 * BIT_CLK);
    chk("t3_ferr_once", fe_cnt - fe0, 1);
    chk("t3_no_valid", rx_valid, 0);
    chk("t3_vrise", vrise_cnt, 1);
    chk("t3_busy_brk", busy, 1);
    hold(1'b1, BIT_CLK);
    chk("t3_idle", busy, 0);
    send_frame(8'h55, 1'b1);
    hold(1'b1, 10);
    chk("t3_data", pop_got(), 8'h55);
    chk("t3_ferr_total", fe_cnt - fe0, 1);

    // 4: consumer stalled, two back-to-back frames -> overrun on the second
    rx_ready = 1'b0;
    got_q.delete();
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    hold(1'b1, 10);
    chk("t4_data", rx_data, 8'h11);
    chk("t4_valid", rx_valid, 1);
    chk("t4_ovr", ov_cnt - ov0, 1);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    chk("t4_drained", rx_valid, 0);
    chk("t4_accepted", pop_got(), 8'h11);

    // 5: locate the deliver clk from an overrun, then accept exactly there
    send_frame(8'h11, 1'b1);
    hold(1'b1, 50);
    ov0 = ov_cnt;
    found = 1'b0;
    k = 0;
    ov_len = 0;
    align();
    fork
      send_frame(8'h33, 1'b1);
      begin
        for (n = 1; n <= 700; n++) begin
          @(posedge clk);
          #1;
          if (overrun) begin
            ov_len++;
            if (!found) begin
              found = 1'b1;
              k = n;
            end
          end
        end
      end
    join
    chk("t5_calib_found", found, 1);
    chk("t5_ovr_width", ov_len, 1);
    chk("t5_kept_old", rx_data, 8'h11);
    hold(1'b1, 50);
    ov0 = ov_cnt;
    vr0 = vrise_cnt;
    got_q.delete();
    align();
    fork
      send_frame(8'h22, 1'b1);
      begin
        if (found) begin
          repeat (k - 1) @(posedge clk);
          #1;
          rx_ready = 1'b1;
          @(posedge clk);
          #1;
          rx_ready = 1'b0;
        end
      end
    join
    hold(1'b1, 10);
    chk("t5_data", rx_data, 8'h22);
    chk("t5_valid", rx_valid, 1);
    chk("t5_no_ovr", ov_cnt - ov0, 0);
    chk("t5_no_drop", vrise_cnt - vr0, 0);
    chk("t5_old_taken", pop_got(), 8'h11);

    // 6: reset during data bit 3 of 0xF0
    rx_ready = 1'b1;
    hold(1'b1, 5);
    got_q.delete();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    hold(1'b0, BIT_CLK);
    hold(1'b0, 3 * BIT_CLK);
    hold(1'b0, BIT_CLK / 2);
    rst_n = 1'b0;
    #2;
    chk("t6_busy", busy, 0);
    chk("t6_valid", rx_valid, 0);
    chk("t6_data", rx_data, 0);
    chk("t6_ferr", frame_err, 0);
    chk("t6_ovr", overrun, 0);
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(1'b1, BIT_CLK);
    send_frame(8'h0F, 1'b1);
    hold(1'b1, 10);
    chk("t6_next", pop_got(), 8'h0F);
    chk("t6_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    // Randomized bytes with random inter-frame gaps (random tick phase)
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      gap = $urandom_range(0, 100);
      exp_q.push_back(b);
      send_frame(b, 1'b1);
      hold(1'b1, gap);
    end
    hold(1'b1, 10);
    chk("rnd_count", got_q.size(), exp_q.size());
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("rnd_byte%0d", i), pop_got(), exp_q[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
